// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters using round-robin
// arbitration. Operands are registered toward the ALU. The result is captured
// one cycle later and returned on a single response channel tagged with the
// requester id.

module alu_share_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [WIDTH-1:0]  req0_a,
   input  logic [WIDTH-1:0]  req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [WIDTH-1:0]  req1_a,
   input  logic [WIDTH-1:0]  req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic              last_grant;
   logic              cur_id;
   logic              op_err;
   logic              grant0;
   logic              grant1;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;
   logic [CTRL_W-1:0] sel_ctrl;
   logic              sel_legal;

   // Any code outside the decoder's table, including X/Z, is illegal.
   function automatic logic ctrl_legal(input logic [CTRL_W-1:0] code);
      logic legal;
      case (code)
         CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(3), CTRL_W'(4),
         CTRL_W'(5), CTRL_W'(6), CTRL_W'(7), CTRL_W'(8), CTRL_W'(10):
            legal = 1'b1;
         default:
            legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Round-robin grant. Grants are offered only in IDLE. On contention the
   // requester that did not win last time gets the grant.
   always_comb begin
      grant0    = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
      grant1    = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
      sel_a     = grant1 ? req1_a    : req0_a;
      sel_b     = grant1 ? req1_b    : req0_b;
      sel_ctrl  = grant1 ? req1_ctrl : req0_ctrl;
      sel_legal = ctrl_legal(sel_ctrl);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Operation sequencer. Accept in IDLE, capture the ALU output in EXEC, and
   // hold the response in RESP until the consumer takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= '0;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         op_err     <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  if (sel_legal) begin
                     alu_a    <= sel_a;
                     alu_b    <= sel_b;
                     alu_ctrl <= sel_ctrl;
                  end
                  cur_id     <= grant1;
                  last_grant <= grant1;
                  op_err     <= !sel_legal;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= op_err ? '0 : alu_result;
               rsp_zero   <= op_err ? 1'b0 : alu_zero;
               rsp_err    <= op_err;
               rsp_id     <= cur_id;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Drives directed scenarios followed by randomized traffic into the shared
// ALU arbiter. A behavioural model tracks the outstanding operation and
// checks every output on each falling clock edge.

module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0;
   logic        req0_ready;
   logic [31:0] req0_a = '0;
   logic [31:0] req0_b = '0;
   logic [3:0]  req0_ctrl = '0;
   logic        req1_valid = 1'b0;
   logic        req1_ready;
   logic [31:0] req1_a = '0;
   logic [31:0] req1_b = '0;
   logic [3:0]  req1_ctrl = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference ALU. It serves as the shared combinational ALU and also
   // produces the model's expected results.
   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
      case (c)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd3:    return a << b[4:0];
         4'd4:    return {31'b0, ($signed(a) < $signed(b))};
         4'd5:    return {31'b0, (a < b)};
         4'd6:    return a - b;
         4'd7:    return a ^ b;
         4'd8:    return a >> b[4:0];
         4'd10:   return 32'($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit is_legal(input logic [3:0] c);
      if ($isunknown(c)) return 1'b0;
      return (c <= 4'd8) || (c == 4'd10);
   endfunction

   assign alu_result = ref_alu(alu_a, alu_b, alu_ctrl);
   assign alu_zero   = (alu_result == 32'd0);

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired, got no event expected event at %0t", name, $time);
   endtask

   // Behavioural model. It tracks whether one operation is outstanding and how
   // many edges have passed since it was accepted.
   bit          m_pending = 1'b0;
   int          m_age = 0;
   bit          m_id = 1'b0;
   bit          m_last = 1'b1;
   logic [31:0] m_res = '0;
   bit          m_zero = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_a = '0;
   logic [31:0] m_b = '0;
   logic [3:0]  m_ctrl = '0;
   bit          e0, e1, erv;
   logic [31:0] s_a, s_b;
   logic [3:0]  s_c;

   // Per-cycle comparison against the model, followed by a model advance.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_pending = 1'b0; m_age = 0; m_last = 1'b1;
         m_a = '0; m_b = '0; m_ctrl = '0;
      end else begin
         e0  = !m_pending && req0_valid && (!req1_valid || m_last);
         e1  = !m_pending && req1_valid && (!req0_valid || !m_last);
         erv = m_pending && (m_age >= 1);
         check_output("req0_ready", 32'(req0_ready), 32'(e0));
         check_output("req1_ready", 32'(req1_ready), 32'(e1));
         check_output("busy", 32'(busy), 32'(m_pending));
         check_output("rsp_valid", 32'(rsp_valid), 32'(erv));
         check_output("alu_a", alu_a, m_a);
         check_output("alu_b", alu_b, m_b);
         check_output("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
         if (erv) begin
            check_output("rsp_id", 32'(rsp_id), 32'(m_id));
            check_output("rsp_result", rsp_result, m_res);
            check_output("rsp_zero", 32'(rsp_zero), 32'(m_zero));
            check_output("rsp_err", 32'(rsp_err), 32'(m_err));
         end
         if (m_pending) begin
            if (erv && rsp_ready) m_pending = 1'b0;
            else m_age = m_age + 1;
         end else if (e0 || e1) begin
            s_a = e1 ? req1_a : req0_a;
            s_b = e1 ? req1_b : req0_b;
            s_c = e1 ? req1_ctrl : req0_ctrl;
            m_id = e1; m_last = e1; m_pending = 1'b1; m_age = 0;
            if (is_legal(s_c)) begin
               m_res = ref_alu(s_a, s_b, s_c); m_zero = (m_res == 32'd0); m_err = 1'b0;
               m_a = s_a; m_b = s_b; m_ctrl = s_c;
            end else begin
               m_res = '0; m_zero = 1'b0; m_err = 1'b1;
            end
         end
      end
   end

   task automatic apply_stimulus(input bit which, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] c);
      if (which) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
      end
   endtask

   task automatic random_op(input bit which);
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      apply_stimulus(which, a, b, 4'($urandom_range(0, 15)));
   endtask

   task automatic wait_ready(input bit which, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if ((which ? req1_ready : req0_ready) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail(which ? "wait_req1_ready" : "wait_req0_ready");
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("wait_rsp_valid");
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy === 1'b0 && rsp_valid === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("wait_idle");
   endtask

   // Issues one operation with rsp_ready high and returns the response fields.
   task automatic run_op(input bit which, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c, output logic [31:0] res, output logic z,
                         output logic id, output logic err);
      bit ok;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      apply_stimulus(which, a, b, c);
      wait_ready(which, ok);
      @(posedge clk); #1;
      if (which) req1_valid = 1'b0; else req0_valid = 1'b0;
      wait_rsp(ok);
      res = rsp_result; z = rsp_zero; id = rsp_id; err = rsp_err;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      logic [31:0] res;
      logic        z, id, err;
      bit          ok, acc0, acc1;
      int          grants[$];

      // Reset state
      #2;
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_alu_a", alu_a, 32'd0);
      check_output("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      #14 rst_n = 1'b1;

      // T1: req0 add 5+3 with a one-cycle EXEC gap before the response
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      apply_stimulus(1'b0, 32'd5, 32'd3, 4'b0010);
      wait_ready(1'b0, ok);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      check_output("t1_exec_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check_output("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("t1_result", rsp_result, 32'd8);
      check_output("t1_zero", 32'(rsp_zero), 32'd0);
      check_output("t1_id", 32'(rsp_id), 32'd0);
      check_output("t1_err", 32'(rsp_err), 32'd0);
      wait_idle();

      // T2: both requesters valid continuously after reset, grants alternate
      do_reset();
      apply_stimulus(1'b0, 32'd1, 32'd1, 4'b0010);
      apply_stimulus(1'b1, 32'hF0, 32'h0F, 4'b0111);
      rsp_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (req0_ready) grants.push_back(0);
         if (req1_ready) grants.push_back(1);
         if (rsp_valid) check_output("t2_result", rsp_result, rsp_id ? 32'hFF : 32'h2);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_idle();
      check_output("t2_grant_count", 32'(grants.size() >= 4), 32'd1);
      for (int i = 0; i < 4; i++)
         check_output("t2_grant_order", (i < grants.size()) ? 32'(grants[i]) : 32'd2, 32'(i % 2));

      // T3: req1 sub 7-7 produces zero
      run_op(1'b1, 32'd7, 32'd7, 4'b0110, res, z, id, err);
      check_output("t3_result", res, 32'd0);
      check_output("t3_zero", 32'(z), 32'd1);
      check_output("t3_id", 32'(id), 32'd1);
      wait_idle();

      // T4: response stalled while both requesters wait
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      apply_stimulus(1'b0, 32'd100, 32'd23, 4'b0010);
      wait_ready(1'b0, ok);
      @(posedge clk); #1;
      apply_stimulus(1'b0, 32'd9, 32'd4, 4'b0001);
      apply_stimulus(1'b1, 32'h12345678, 32'd8, 4'b1000);
      wait_rsp(ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("t4_hold_result", rsp_result, 32'd123);
         check_output("t4_hold_valid", 32'(rsp_valid), 32'd1);
         check_output("t4_hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
         check_output("t4_hold_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_output("t4_rr_req1_ready", 32'(req1_ready), 32'd1);
      check_output("t4_rr_req0_ready", 32'(req0_ready), 32'd0);
      check_output("t4_rsp_valid_low", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_ready(1'b0, ok);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_idle();

      // T5: illegal ctrl leaves the ALU operands from the previous legal op
      run_op(1'b0, 32'hDEAD, 32'hBEEF, 4'hF, res, z, id, err);
      check_output("t5_err", 32'(err), 32'd1);
      check_output("t5_result", res, 32'd0);
      check_output("t5_zero", 32'(z), 32'd0);
      check_output("t5_alu_a", alu_a, 32'd9);
      check_output("t5_alu_b", alu_b, 32'd4);
      check_output("t5_alu_ctrl", 32'(alu_ctrl), 32'd1);
      wait_idle();

      // T6: reset during EXEC clears outputs without a clock, then req0 wins first
      @(posedge clk); #1;
      apply_stimulus(1'b0, 32'd77, 32'd1, 4'b0010);
      wait_ready(1'b0, ok);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      check_output("t6_pre_alu_a", alu_a, 32'd77);
      #1 rst_n = 1'b0;
      #1;
      check_output("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("t6_busy", 32'(busy), 32'd0);
      check_output("t6_alu_a", alu_a, 32'd0);
      check_output("t6_alu_b", alu_b, 32'd0);
      check_output("t6_alu_ctrl", 32'(alu_ctrl), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply_stimulus(1'b0, 32'd5, 32'd5, 4'b0110);
      apply_stimulus(1'b1, 32'd3, 32'd6, 4'b0000);
      @(negedge clk);
      check_output("t6_first_req0", 32'(req0_ready), 32'd1);
      check_output("t6_first_req1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_ready(1'b1, ok);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_idle();

      // Randomized traffic with random response back-pressure
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         acc0 = req0_ready;
         acc1 = req1_ready;
         @(posedge clk); #1;
         if (req0_valid && acc0) begin
            if ($urandom_range(0, 1) == 1) random_op(1'b0); else req0_valid = 1'b0;
         end else if (req0_valid) begin
            if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
         end else if ($urandom_range(0, 2) != 0) begin
            random_op(1'b0);
         end
         if (req1_valid && acc1) begin
            if ($urandom_range(0, 1) == 1) random_op(1'b1); else req1_valid = 1'b0;
         end else if (req1_valid) begin
            if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
         end else if ($urandom_range(0, 2) != 0) begin
            random_op(1'b1);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
